// File: rtl/mat_mult_stream_ctrl.sv
// Serial valid/ready front/back end for the square matrix multiplier: loads A then B, runs the array, streams A*B out.
// Optional WAIT watchdog built when MAT_CTRL_TIMEOUT_EN is defined; otherwise timeout_err is tied low.
module mat_mult_stream_ctrl #(
    parameter int N_ROWS         = 2,
    parameter int N_COLUMNS      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic               out_last,
    output logic               enable_mult,
    output logic signed [31:0] mat1    [N_ROWS][N_COLUMNS],
    output logic signed [31:0] mat2    [N_ROWS][N_COLUMNS],
    input  logic signed [31:0] mat_out [N_ROWS][N_COLUMNS],
    input  logic               mult_done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int NN    = N_ROWS * N_COLUMNS;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    if (N_ROWS != N_COLUMNS || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mat_mult_stream_ctrl: N_ROWS must equal N_COLUMNS and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt, idx_p1;
    logic                   wait_first;
    logic                   in_hs, out_hs, capture, abort, wd_expired;
    logic signed [31:0]     result [N_ROWS][N_COLUMNS];
    logic signed [31:0]     rd_word;

    assign in_ready = !reset && (state == LOAD_A || state == LOAD_B);
    assign idx_p1   = idx + 1'b1;

    always_comb begin
        state_nxt = state;
        in_hs     = 1'b0;
        out_hs    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            LOAD_A: begin
                in_hs = in_valid;
                if (in_valid && idx == LAST_IDX) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                in_hs = in_valid;
                if (in_valid && idx == LAST_IDX) state_nxt = WAIT;
            end
            WAIT: begin
                // A done still asserted from the previous job must not be taken as this job's completion
                if (!wait_first && mult_done) begin
                    capture   = 1'b1;
                    state_nxt = DRAIN;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = LOAD_A;
                end
            end
            DRAIN: begin
                out_hs = out_ready;
                if (out_ready && idx == LAST_IDX) state_nxt = LOAD_A;
            end
            default: state_nxt = LOAD_A;
        endcase

        if (state_nxt != state)     idx_nxt = '0;
        else if (in_hs || out_hs)   idx_nxt = idx_p1;
        else                        idx_nxt = idx;
    end

    // Word that follows the one currently presented on out_data
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLUMNS; c++) begin
                if (idx_p1 == IDX_W'(r * N_COLUMNS + c)) rd_word = result[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD_A;
            idx         <= '0;
            wait_first  <= 1'b0;
            enable_mult <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            for (int r = 0; r < N_ROWS; r++) begin
                for (int c = 0; c < N_COLUMNS; c++) begin
                    mat1[r][c]   <= '0;
                    mat2[r][c]   <= '0;
                    result[r][c] <= '0;
                end
            end
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            wait_first  <= (state != WAIT) && (state_nxt == WAIT);
            enable_mult <= (state_nxt == WAIT);
            busy        <= (state_nxt == WAIT) || (state_nxt == DRAIN);

            // B arrives row-major but is stored transposed so each mat2 row is a B column
            for (int r = 0; r < N_ROWS; r++) begin
                for (int c = 0; c < N_COLUMNS; c++) begin
                    if (in_hs && state == LOAD_A && idx == IDX_W'(r * N_COLUMNS + c))
                        mat1[r][c] <= in_data;
                    if (in_hs && state == LOAD_B && idx == IDX_W'(r * N_COLUMNS + c))
                        mat2[c][r] <= in_data;
                    if (capture)
                        result[r][c] <= mat_out[r][c];
                end
            end

            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= mat_out[0][0];
                out_last  <= (NN == 1);
            end else if (out_hs) begin
                if (idx == LAST_IDX) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_data  <= rd_word;
                    out_last  <= (idx_p1 == LAST_IDX);
                end
            end
        end
    end

`ifdef MAT_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign wd_expired = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT)    wait_cnt <= '0;
            else if (!wd_expired) wait_cnt <= wait_cnt + 1'b1;
            if (abort)            timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mat_mult_stream_ctrl.sv
// Scoreboard bench for mat_mult_stream_ctrl with N=2 and a behavioural multiplier model.
module tb_mat_mult_stream_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic               out_last;
    logic               enable_mult;
    logic signed [31:0] mat1    [2][2];
    logic signed [31:0] mat2    [2][2];
    logic signed [31:0] mat_out [2][2];
    logic               mult_done;
    logic               busy;
    logic               timeout_err;

    mat_mult_stream_ctrl #(
        .N_ROWS(2), .N_COLUMNS(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .enable_mult(enable_mult), .mat1(mat1), .mat2(mat2), .mat_out(mat_out),
        .mult_done(mult_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int data; bit last; } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, n_pops = 0, last_pop_cyc = 0, n_valid_seen = 0;
    int en_cnt = 0, last_en = 0, done_mode = 0;
    bit bp_en = 0, hold_prev = 0, prev_last = 0;
    int prev_data = 0;

    int a_basic [4] = '{1, 2, 3, 4};
    int b_basic [4] = '{5, 6, 7, 8};
    int a_ident [4] = '{1, 0, 0, 1};
    int b_alt   [4] = '{9, 8, 7, 6};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Output monitor, backpressure driver and multiplier model, all updated on the falling edge
    always @(negedge clk) begin
        cyc++;
        out_ready = bp_en ? (cyc % 3 == 0) : 1'b1;
        if (out_valid) n_valid_seen++;
        if (hold_prev) begin
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
        end
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
            end
            n_pops++;
            last_pop_cyc = cyc;
        end
        if (enable_mult) en_cnt++;
        else begin
            if (en_cnt != 0) last_en = en_cnt;
            en_cnt = 0;
        end
        case (done_mode)
            0:       mult_done = (en_cnt == 3);
            1:       mult_done = (en_cnt == 1) || (en_cnt == 5);
            default: mult_done = 1'b0;
        endcase
    end

    task automatic send_word(input int w);
        int  guard = 0;
        bit  took  = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!took && guard < 200) begin
            took = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!took) check("send_accept", took, 1);
    endtask

    task automatic load_job(input int a [4], input int b [4], input int gap, input int mode);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                mat_out[r][c] = a[r*2] * b[c] + a[r*2+1] * b[2+c];
        if (mode != 2)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(exp_t'{mat_out[i/2][i%2], i == 3});
        done_mode = mode;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (gap) tick();
            send_word(i < 4 ? a[i] : b[i-4]);
        end
        check("wait_enable", enable_mult, 1);
        check("wait_in_ready", in_ready, 0);
        check("wait_busy", busy, 1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                check("mat1", mat1[r][c], a[r*2+c]);
                check("mat2", mat2[c][r], b[r*2+c]);
            end
    endtask

    task automatic run_job(input int a [4], input int b [4], input int gap, input int mode);
        int guard = 0;
        int v0;
        v0 = n_valid_seen;
        load_job(a, b, gap, mode);
        while (!in_ready && guard < 300) begin
            tick();
            guard++;
        end
        check("back_to_load", in_ready, 1);
        check("busy_idle", busy, 0);
        check("enable_idle", enable_mult, 0);
        if (mode == 2) begin
            check("to_err", timeout_err, 1);
            check("to_wait_len", last_en, 10);
            check("to_no_out", n_valid_seen, v0);
        end else begin
            check("q_drained", exp_q.size(), 0);
            check("ready_after_last", cyc - last_pop_cyc, 1);
            check("wait_len", last_en, mode == 1 ? 5 : 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        int p0;
        reset = 1'b1; in_valid = 1'b0; in_data = 0; mult_done = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) mat_out[r][c] = 0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_enable", enable_mult, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_ready_after", in_ready, 1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                check("rst_mat1", mat1[r][c], 0);
                check("rst_mat2", mat2[r][c], 0);
            end

        run_job(a_basic, b_basic, 0, 0);
        bp_en = 1;
        run_job(a_basic, b_basic, 0, 0);
        bp_en = 0;
        run_job(a_basic, b_basic, 0, 1);
        run_job(a_basic, b_basic, 2, 0);

        // Abort a job part-way through the drain
        load_job(a_basic, b_basic, 0, 0);
        p0 = n_pops;
        guard = 0;
        while (n_pops == p0 && guard < 100) begin
            tick();
            guard++;
        end
        check("first_word_seen", n_pops - p0, 1);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_enable", enable_mult, 0);
        check("midrst_load_a", in_ready, 1);
        exp_q.delete();
        run_job(a_ident, b_alt, 0, 0);

`ifdef MAT_CTRL_TIMEOUT_EN
        run_job(a_basic, b_basic, 0, 2);
        tick();
        check("to_sticky", timeout_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("to_cleared", timeout_err, 0);
`else
        check("no_timeout", timeout_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
